mfp_reset_sequencer: RTL
========================

# mfp_reset_sequencer

Parametrised multi-channel reset sequencer for the MIPSfpga system top. It generates N_CHANNELS active-low reset outputs (for example EJTAG TRST_N, core SI_Reset, peripherals) and holds all of them asserted for a programmable interval. It then releases them one at a time in channel order with a programmable gap between releases. A software or loader request re-runs the full sequence. An optional watchdog re-triggers the sequence if software stops kicking it. It generalises the fixed 16-cycle single-output EJTAG reset pulser.

## Interface
Parameters:
- N_CHANNELS, 3: number of reset outputs; at least 1.
- HOLD_CYCLES, 16: cycles that all outputs stay asserted after sequence start; at least 1.
- STAGE_GAP, 8: cycles between consecutive channel releases; 0 releases all channels together.
- WDT_CYCLES, 1048576: watchdog timeout in cycles; used only with the macro; at least 2.

Ports:
- SI_ClkIn  in  1  system clock; the only clock.
- SI_Reset  in  1  reset; synchronous, active-high. It restarts the sequence and has priority over every other input.
- sw_reset_req  in  1  single-cycle request to re-run the full sequence, e.g. the loader's MFP_Reset.
- wdt_kick  in  1  watchdog restart strobe; ignored when the watchdog is compiled out.
- rst_n_out  out  N_CHANNELS  active-low resets; bit 0 is released first.
- busy  out  1  high while any rst_n_out bit is low.
- seq_done  out  1  one-cycle pulse in the cycle the last channel is released.
- wdt_expired  out  1  one-cycle pulse when the watchdog times out; constant 0 when compiled out.

## Operation
- State machine states: HOLD, RELEASE, DONE.
- Each state register has a declaration initialiser equal to its reset value, so the sequence also runs after FPGA configuration without an SI_Reset pulse.
- While SI_Reset is high:
  - state = HOLD, counter = 0, release index = 0.
  - rst_n_out = all 0, busy = 1, seq_done = 0, wdt_expired = 0.
- HOLD:
  - Counter increments each cycle.
  - At count HOLD_CYCLES-1, rst_n_out[0] is released (set to 1) and the FSM goes to RELEASE with the counter cleared.
  - If N_CHANNELS = 1, the FSM goes straight to DONE instead.
- RELEASE:
  - Counter increments each cycle.
  - At count STAGE_GAP-1, the next channel is released, the index increments and the counter clears.
  - Releasing channel N_CHANNELS-1 moves the FSM to DONE.
  - With STAGE_GAP = 0, all channels release together with channel 0 and the FSM enters DONE directly from HOLD.
- DONE: rst_n_out = all 1, busy = 0. The FSM stays here until a restart.
- Restart: sw_reset_req = 1 (or a watchdog expiry) in any state:
  - Next cycle: state = HOLD, counter = 0, index = 0, rst_n_out = all 0.
  - A request arriving mid-sequence aborts the current sequence and starts over from HOLD.
  - A request held high for several cycles keeps the FSM in HOLD with counter 0; the count starts in the first cycle after the request drops.
- Released bits only ever go 0→1 within a sequence. Outputs are registered and glitch-free.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP)+1). Release index width: $clog2(N_CHANNELS+1).

## Timing
- Cycle 0 is the first cycle with SI_Reset = 0 (or the first cycle after the request drops).
- rst_n_out[k] goes high in cycle HOLD_CYCLES + k·STAGE_GAP.
- seq_done = 1 in cycle HOLD_CYCLES + (N_CHANNELS-1)·STAGE_GAP.
- busy falls in that same cycle.
- Restart latency: outputs are asserted low one cycle after sw_reset_req is sampled.
- All inputs are sampled on the rising edge of SI_ClkIn. Inputs are synchronous to SI_ClkIn; asynchronous sources must be synchronised externally.

## Configuration
- MFP_RESET_SEQ_WATCHDOG_EN defined:
  - A $clog2(WDT_CYCLES)-bit counter runs only in DONE. It clears on wdt_kick and is held at 0 outside DONE.
  - When it reaches WDT_CYCLES-1 without a kick, wdt_expired pulses for one cycle and the FSM restarts exactly as for sw_reset_req.
  - wdt_kick in the same cycle as the terminal count wins: no expiry.
- MFP_RESET_SEQ_WATCHDOG_EN undefined: no watchdog counter is built, wdt_kick is ignored, wdt_expired = 0. The block never restarts on its own.

## Test plan
- Defaults, SI_Reset high for 3 cycles then low: rst_n_out = 000 until cycle 16; 001 at cycle 16, 011 at 24, 111 at 32; seq_done is high only at cycle 32; busy is 0 from cycle 32.
- sw_reset_req pulsed at cycle 20 (channel 0 already released): rst_n_out = 000 at cycle 21; channel 0 re-released 16 cycles after the request drops; full sequence repeats.
- STAGE_GAP = 0, N_CHANNELS = 4: rst_n_out goes 0000→1111 in a single cycle at cycle 16, with seq_done pulsing in that cycle.
- SI_Reset asserted during RELEASE (rst_n_out = 011): the next cycle shows 000; after release the sequence restarts from cycle 0; sw_reset_req applied at the same time is overridden by SI_Reset.
- Watchdog compiled in, WDT_CYCLES = 64, no kicks: wdt_expired pulses 64 cycles after DONE and rst_n_out drops to 000. With a kick every 50 cycles it never expires. Compiled out: wdt_expired stays 0 for 10000 cycles.
- Post-configuration start with no SI_Reset pulse (initialisers only): release times match the first scenario.

Source files
------------

// File: rtl/mfp_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mfp_reset_sequencer
// Purpose  : Multi-channel reset sequencer for the MIPSfpga system top.
//            Holds every active-low reset output asserted for HOLD_CYCLES,
//            then releases the channels one at a time (bit 0 first) with
//            STAGE_GAP cycles between releases. A software/loader request,
//            or an optional watchdog timeout, re-runs the full sequence.
//
// Parameters:
//   N_CHANNELS  - number of reset outputs (>= 1)
//   HOLD_CYCLES - cycles all outputs stay low after sequence start (>= 1)
//   STAGE_GAP   - cycles between consecutive releases; 0 = release together
//   WDT_CYCLES  - watchdog timeout in cycles (>= 2), watchdog builds only
//
// Ports:
//   SI_ClkIn     in   1           system clock
//   SI_Reset     in   1           synchronous active-high reset, top priority
//   sw_reset_req in   1           request to re-run the sequence
//   wdt_kick     in   1           watchdog restart strobe
//   rst_n_out    out  N_CHANNELS  active-low resets, bit 0 released first
//   busy         out  1           high while any rst_n_out bit is low
//   seq_done     out  1           pulse in the cycle the last channel releases
//   wdt_expired  out  1           pulse when the watchdog times out
//
// Build option:
//   MFP_RESET_SEQ_WATCHDOG_EN - when defined, a watchdog counter runs in the
//   DONE state and restarts the sequence if wdt_kick stops arriving. When
//   undefined, wdt_kick is ignored and wdt_expired is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module mfp_reset_sequencer #(
    parameter int N_CHANNELS  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDT_CYCLES  = 1048576
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset,
    input  logic                  sw_reset_req,
    input  logic                  wdt_kick,
    output logic [N_CHANNELS-1:0] rst_n_out,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  wdt_expired
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_MAX  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W    = $clog2(N_CHANNELS + 1);
    localparam int c_WDT_W    = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

    // The gap terminal count is unreachable when STAGE_GAP is 0 (RELEASE is
    // never entered); clamp it so the compare constant stays non-negative.
    localparam int c_GAP_TERM = (STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0;

    // All channels leave reset together when there is no gap or only one
    // channel exists, so HOLD goes straight to DONE.
    localparam bit c_SKIP_RELEASE = (STAGE_GAP == 0) || (N_CHANNELS == 1);

    localparam logic [c_CNT_W-1:0]    c_HOLD_TERM_V = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_GAP_TERM_V  = c_CNT_W'(c_GAP_TERM);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX    = c_IDX_W'(N_CHANNELS - 1);
    localparam logic [N_CHANNELS-1:0] c_ALL_ONES    = {N_CHANNELS{1'b1}};
    localparam logic [N_CHANNELS-1:0] c_CH0_MASK    = N_CHANNELS'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_HOLD    = 2'd0;
    localparam logic [1:0] c_S_RELEASE = 2'd1;
    localparam logic [1:0] c_S_DONE    = 2'd2;

    // ------------------------------------------------------------------------
    // Registers. Declaration initialisers equal the reset values so the
    // sequence also runs straight out of FPGA configuration.
    // ------------------------------------------------------------------------
    logic [1:0]            r_state    = c_S_HOLD;
    logic [c_CNT_W-1:0]    r_cnt      = '0;
    logic [c_IDX_W-1:0]    r_idx      = '0;
    logic [N_CHANNELS-1:0] r_rst_n    = '0;
    logic                  r_busy     = 1'b1;
    logic                  r_seq_done = 1'b0;
    logic                  r_wdt_exp  = 1'b0;

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [N_CHANNELS-1:0] w_rst_n_nxt;
    logic                  w_done_nxt;
    logic                  w_wdt_fire;
    logic                  w_restart;
    logic [N_CHANNELS-1:0] w_rel_mask;

    // One-hot mask selecting the channel addressed by the release index.
    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_rel_mask
            assign w_rel_mask[gi] = (r_idx == c_IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
`ifdef MFP_RESET_SEQ_WATCHDOG_EN
    localparam logic [c_WDT_W-1:0] c_WDT_TERM = c_WDT_W'(WDT_CYCLES - 1);

    logic [c_WDT_W-1:0] r_wdt_cnt = '0;

    // A kick in the terminal-count cycle wins over the expiry.
    assign w_wdt_fire = (r_state == c_S_DONE) && !wdt_kick && (r_wdt_cnt == c_WDT_TERM);

    // Counts only while DONE; any kick, expiry or restart request clears it,
    // and it is held at zero in every other state.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_wdt_cnt <= '0;
        end else if ((r_state != c_S_DONE) || wdt_kick || w_wdt_fire || sw_reset_req) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + c_WDT_W'(1);
        end
    end
`else
    // Watchdog compiled out: the kick strobe and timeout width have no load.
    logic [c_WDT_W-1:0] w_unused_wdt;
    assign w_unused_wdt = {c_WDT_W{wdt_kick}};
    assign w_wdt_fire   = 1'b0;
`endif

    assign w_restart = sw_reset_req | w_wdt_fire;

    // ------------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = 1'b0;

        if (w_restart) begin
            // Abort whatever is in progress and start again from HOLD. While
            // the request stays high the counter is pinned at zero.
            w_state_nxt = c_S_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_n_nxt = '0;
        end else begin
            case (r_state)
                c_S_HOLD: begin
                    if (r_cnt == c_HOLD_TERM_V) begin
                        w_cnt_nxt = '0;
                        if (c_SKIP_RELEASE) begin
                            w_rst_n_nxt = c_ALL_ONES;
                            w_state_nxt = c_S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            // Channel 0 leaves reset; index now points at
                            // the next channel to release.
                            w_rst_n_nxt = r_rst_n | c_CH0_MASK;
                            w_idx_nxt   = c_IDX_W'(1);
                            w_state_nxt = c_S_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end

                c_S_RELEASE: begin
                    if (r_cnt == c_GAP_TERM_V) begin
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = r_rst_n | w_rel_mask;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end

                c_S_DONE: begin
                    w_rst_n_nxt = c_ALL_ONES;
                end

                default: begin
                    // Unused encoding: fall back to a clean sequence start.
                    w_state_nxt = c_S_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. busy is registered from the next-state
    // reset vector so it changes in the same cycle as rst_n_out, glitch-free.
    // ------------------------------------------------------------------------
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_state    <= c_S_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_n    <= '0;
            r_busy     <= 1'b1;
            r_seq_done <= 1'b0;
            r_wdt_exp  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_busy     <= ~&w_rst_n_nxt;
            r_seq_done <= w_done_nxt;
            r_wdt_exp  <= w_wdt_fire;
        end
    end

    assign rst_n_out   = r_rst_n;
    assign busy        = r_busy;
    assign seq_done    = r_seq_done;
    assign wdt_expired = r_wdt_exp;

endmodule
`default_nettype wire
